// File: rtl/exc_pc_ctrl.sv
// Exception/interrupt PC redirection and the EPC/CAUSE/STATUS registers.
// The redirect and flush are combinational in the commit cycle; register updates land on the next edge.
`timescale 1ns/1ps
module exc_pc_ctrl #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(32'h00004180),
  parameter int unsigned      NUM_IRQ = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   npc,
  input  logic [WIDTH-1:0]   cur_pc,
  input  logic               in_bd,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               eret,
  input  logic               stall,
  input  logic               sr_we,
  input  logic [WIDTH-1:0]   sr_wdata,
  output logic [WIDTH-1:0]   rnpc,
  output logic [WIDTH-1:0]   epc,
  output logic [31:0]        cause,
  output logic [31:0]        status,
  output logic               flush
);

  typedef enum logic [0:0] {StNormal, StHandler} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   epc_q, epc_d;
  logic [4:0]         code_q, code_d;
  logic               bd_q, bd_d;
  logic [NUM_IRQ-1:0] ip_q;
  logic               ie_q, ie_d;
  logic [NUM_IRQ-1:0] im_q, im_d;

  logic exl;
  logic exc_take, int_take, eret_take;
  logic unused_sr;

  assign exl = (state_q == StHandler);

  // Gating with rst_n keeps rnpc == npc and flush low while reset is held.
  assign exc_take  = rst_n & exc_req & ~stall;
  assign int_take  = rst_n & ~stall & ~exc_take & ie_q & ~exl & (|(ip_q & im_q));
  assign eret_take = rst_n & eret & ~stall & ~exc_take & ~int_take;

  assign flush = exc_take | int_take | eret_take;

  always_comb begin
    rnpc = npc;
    if (exc_take || int_take) begin
      rnpc = EXC_VEC;
    end else if (eret_take) begin
      rnpc = epc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    bd_d    = bd_q;
    code_d  = code_q;
    ie_d    = ie_q;
    im_d    = im_q;
    if (exc_take || int_take) begin
      code_d = exc_take ? exc_code : 5'd0;
      // A nested exception keeps the original return context.
      if (state_q == StNormal) begin
        epc_d   = in_bd ? (cur_pc - WIDTH'(4)) : cur_pc;
        bd_d    = in_bd;
        state_d = StHandler;
      end
    end else if (eret_take) begin
      state_d = StNormal;
    end
    if (sr_we) begin
      ie_d = sr_wdata[0];
      im_d = sr_wdata[8 +: NUM_IRQ];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StNormal;
      epc_q   <= '0;
      bd_q    <= 1'b0;
      code_q  <= '0;
      ip_q    <= '0;
      ie_q    <= 1'b0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      bd_q    <= bd_d;
      code_q  <= code_d;
      ip_q    <= irq;
      ie_q    <= ie_d;
      im_q    <= im_d;
    end
  end

  always_comb begin
    cause              = '0;
    cause[31]          = bd_q;
    cause[8 +: NUM_IRQ] = ip_q;
    cause[6:2]         = code_q;
  end

  always_comb begin
    status               = '0;
    status[8 +: NUM_IRQ] = im_q;
    status[1]            = exl;
    status[0]            = ie_q;
  end

  assign epc       = epc_q;
  assign unused_sr = ^sr_wdata;

endmodule

// File: tb/tb_exc_pc_ctrl.sv
// Directed self-checking bench for exc_pc_ctrl with default parameters.
`timescale 1ns/1ps
module tb_exc_pc_ctrl;

  logic        clk, rst_n;
  logic [31:0] npc, cur_pc, sr_wdata;
  logic        in_bd, exc_req, eret, stall, sr_we;
  logic [4:0]  exc_code;
  logic [5:0]  irq;
  logic [31:0] rnpc, epc, cause, status;
  logic        flush;

  int checks = 0;
  int errors = 0;

  exc_pc_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .npc      (npc),
    .cur_pc   (cur_pc),
    .in_bd    (in_bd),
    .exc_req  (exc_req),
    .exc_code (exc_code),
    .irq      (irq),
    .eret     (eret),
    .stall    (stall),
    .sr_we    (sr_we),
    .sr_wdata (sr_wdata),
    .rnpc     (rnpc),
    .epc      (epc),
    .cause    (cause),
    .status   (status),
    .flush    (flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; npc = 32'h100; exc_req = 1'b1; exc_code = 5'd3;
    #12;
    chk32("reset_rnpc", rnpc, 32'h100);
    chk1("reset_flush", flush, 1'b0);
    chk32("reset_epc", epc, 32'h0);
    chk32("reset_cause", cause, 32'h0);
    chk32("reset_status", status, 32'h0);
    exc_req = 1'b0;
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_exc();
    npc = 32'h3014; cur_pc = 32'h3010; in_bd = 1'b0; exc_req = 1'b1; exc_code = 5'd12;
    #1;
    chk32("exc_rnpc", rnpc, 32'h4180);
    chk1("exc_flush", flush, 1'b1);
    tick();
    exc_req = 1'b0;
    #1;
    chk32("exc_epc", epc, 32'h3010);
    chk32("exc_cause", cause, 32'h30);
    chk32("exc_status", status, 32'h2);
    chk32("exc_idle_rnpc", rnpc, 32'h3014);
    chk1("exc_idle_flush", flush, 1'b0);
  endtask

  task automatic test_nested();
    exc_req = 1'b1; exc_code = 5'd5; in_bd = 1'b1; cur_pc = 32'h5000;
    #1;
    chk32("nest_rnpc", rnpc, 32'h4180);
    chk1("nest_flush", flush, 1'b1);
    tick();
    exc_req = 1'b0; in_bd = 1'b0;
    chk32("nest_epc", epc, 32'h3010);
    chk32("nest_cause", cause, 32'h14);
    chk32("nest_status", status, 32'h2);
  endtask

  task automatic test_eret_collision();
    eret = 1'b1; exc_req = 1'b1; exc_code = 5'd7;
    #1;
    chk32("coll_rnpc", rnpc, 32'h4180);
    chk1("coll_flush", flush, 1'b1);
    tick();
    eret = 1'b0; exc_req = 1'b0;
    chk32("coll_status", status, 32'h2);
    chk32("coll_epc", epc, 32'h3010);
    chk32("coll_cause", cause, 32'h1c);
  endtask

  task automatic test_eret();
    eret = 1'b1;
    #1;
    chk32("eret_rnpc", rnpc, 32'h3010);
    chk1("eret_flush", flush, 1'b1);
    tick();
    eret = 1'b0;
    chk32("eret_status", status, 32'h0);
    chk32("eret_epc", epc, 32'h3010);
  endtask

  task automatic test_bd();
    exc_req = 1'b1; in_bd = 1'b1; cur_pc = 32'h3024; exc_code = 5'd4;
    tick();
    exc_req = 1'b0; in_bd = 1'b0;
    chk32("bd_epc", epc, 32'h3020);
    chk32("bd_cause", cause, 32'h8000_0010);
    chk32("bd_status", status, 32'h2);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk32("bd_eret_status", status, 32'h0);
  endtask

  task automatic test_stall();
    npc = 32'h200; cur_pc = 32'h3040; exc_req = 1'b1; exc_code = 5'd9; stall = 1'b1;
    #1;
    chk32("stall_rnpc", rnpc, 32'h200);
    chk1("stall_flush", flush, 1'b0);
    tick();
    chk32("stall_status", status, 32'h0);
    chk32("stall_epc", epc, 32'h3020);
    chk32("stall_cause", cause, 32'h8000_0010);
    stall = 1'b0;
    #1;
    chk32("unstall_rnpc", rnpc, 32'h4180);
    chk1("unstall_flush", flush, 1'b1);
    tick();
    exc_req = 1'b0;
    chk32("unstall_epc", epc, 32'h3040);
    chk32("unstall_cause", cause, 32'h24);
    chk32("unstall_status", status, 32'h2);
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic test_irq();
    sr_we = 1'b1; sr_wdata = 32'h0401;
    tick();
    sr_we = 1'b0;
    chk32("irq_sr_status", status, 32'h401);
    cur_pc = 32'h6000; npc = 32'h6004; irq = 6'b000100;
    #1;
    chk1("irq_sync_flush", flush, 1'b0);
    chk32("irq_sync_rnpc", rnpc, 32'h6004);
    tick();
    chk32("irq_ip_cause", cause, 32'h424);
    chk1("irq_take_flush", flush, 1'b1);
    chk32("irq_take_rnpc", rnpc, 32'h4180);
    tick();
    chk32("irq_status", status, 32'h403);
    chk32("irq_cause", cause, 32'h400);
    chk32("irq_epc", epc, 32'h6000);
    chk1("irq_in_handler_flush", flush, 1'b0);
    irq = 6'b0; eret = 1'b1;
    #1;
    chk32("irq_eret_rnpc", rnpc, 32'h6000);
    tick();
    eret = 1'b0;
    chk32("irq_eret_status", status, 32'h401);
    // IM cleared: a pending line must never be taken.
    sr_we = 1'b1; sr_wdata = 32'h0001;
    tick();
    sr_we = 1'b0; irq = 6'b000100;
    tick();
    tick();
    chk1("mask_flush", flush, 1'b0);
    chk32("mask_rnpc", rnpc, 32'h6004);
    chk32("mask_status", status, 32'h1);
    chk32("mask_cause", cause, 32'h400);
    irq = 6'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    cur_pc = 32'h3010; exc_req = 1'b1; exc_code = 5'd12;
    tick();
    exc_req = 1'b0;
    chk32("mid_pre_status", status, 32'h3);
    chk32("mid_pre_epc", epc, 32'h3010);
    npc = 32'h700; exc_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk32("mid_epc", epc, 32'h0);
    chk32("mid_cause", cause, 32'h0);
    chk32("mid_status", status, 32'h0);
    chk32("mid_rnpc", rnpc, 32'h700);
    chk1("mid_flush", flush, 1'b0);
    exc_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk32("mid_after_status", status, 32'h0);
    chk1("mid_after_flush", flush, 1'b0);
    chk32("mid_after_rnpc", rnpc, 32'h700);
  endtask

  initial begin
    rst_n = 1'b0; npc = '0; cur_pc = '0; in_bd = 1'b0; exc_req = 1'b0; exc_code = '0;
    irq = '0; eret = 1'b0; stall = 1'b0; sr_we = 1'b0; sr_wdata = '0;
    test_reset();
    test_exc();
    test_nested();
    test_eret_collision();
    test_eret();
    test_bd();
    test_stall();
    test_irq();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_pc_ctrl.md
EXC_PC_CTRL -- requirements
Module: exc_pc_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: PC/data width in bits.
REQ-002 Parameter EXC_VEC, default 32'h00004180: exception/interrupt entry address.
REQ-003 Parameter NUM_IRQ, default 6: number of hardware interrupt lines, range 1..8.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port npc, input, WIDTH: sequential next PC from the fetch stage.
REQ-007 Port cur_pc, input, WIDTH: PC of the instruction in the commit stage.
REQ-008 Port in_bd, input, 1: the commit instruction sits in a branch delay slot.
REQ-009 Port exc_req, input, 1: synchronous exception raised by the commit instruction.
REQ-010 Port exc_code, input, 5: cause code for exc_req.
REQ-011 Port irq, input, NUM_IRQ: level-sensitive hardware interrupt lines.
REQ-012 Port eret, input, 1: the commit instruction is ERET.
REQ-013 Port stall, input, 1: the commit stage is frozen this cycle.
REQ-014 Port sr_we, input, 1: status-register write strobe (MTC0 SR).
REQ-015 Port sr_wdata, input, WIDTH: status write data; bit 0 = IE, bits [8+NUM_IRQ-1:8] = IM.
REQ-016 Port rnpc, output, WIDTH: redirected next PC.
REQ-017 Port epc, output, WIDTH: exception return address register.
REQ-018 Port cause, output, 32: {bd[31], zeros, ip[8+NUM_IRQ-1:8], zeros, code[6:2], 2'b00}.
REQ-019 Port status, output, 32: {zeros, IM, zeros, EXL[1], IE[0]}.
REQ-020 Port flush, output, 1: pipeline flush request, asserted in the redirect cycle.

Function
REQ-021 ip register samples irq every cycle (1-cycle sync latency); cause.ip SHALL reflect ip.
REQ-022 int_take = ip & IM nonzero, IE=1, EXL=0, stall=0.
REQ-023 exc_take = exc_req & ~stall; taken regardless of EXL.
REQ-024 eret_take = eret & ~stall & ~exc_take & ~int_take.
REQ-025 Priority: exc_take > int_take > eret_take; at most one event per cycle.
REQ-026 Combinational rnpc: EXC_VEC on exc_take or int_take; epc on eret_take; else npc.
REQ-027 flush SHALL equal exc_take | int_take | eret_take in the same cycle (combinational, 0-cycle latency).
REQ-028 On exc_take or int_take with EXL=0: epc <= in_bd ? cur_pc-4 : cur_pc (modulo 2^WIDTH); bd <= in_bd; EXL <= 1.
REQ-029 On exc_take with EXL=1 (nested): epc, bd and EXL unchanged; code updated; rnpc = EXC_VEC.
REQ-030 Code register: exc_code on exc_take; 5'd0 on int_take; unchanged otherwise.
REQ-031 On eret_take: EXL <= 0; epc unchanged.
REQ-032 sr_we writes IE and IM; EXL not writable via sr_we; if sr_we coincides with an event, the event's EXL update and the sr_we IE/IM update both apply.
REQ-033 stall=1: no event taken, rnpc=npc, flush=0, requests not latched (must be re-presented by the pipeline).
REQ-034 States: NORMAL (EXL=0) -> HANDLER on exc_take/int_take; HANDLER -> NORMAL on eret_take only; HANDLER -> HANDLER on nested exc_take.

Reset
REQ-035 On rst_n=0, asynchronously: epc=0, code=0, bd=0, ip=0, IE=0, IM=0, EXL=0; state NORMAL.
REQ-036 During reset rnpc SHALL equal npc and flush SHALL be 0.
REQ-037 Reset asserted mid-handler SHALL discard EXL and epc; no event resumes after release.

Verification
REQ-038 exc_req=1, exc_code=12, cur_pc=32'h3010, in_bd=0 -> same cycle rnpc=32'h4180, flush=1; next cycle epc=32'h3010, cause[6:2]=12, EXL=1.
REQ-039 exc_req=1, in_bd=1, cur_pc=32'h3024 -> epc=32'h3020, cause[31]=1.
REQ-040 sr_wdata=32'h0401 written, then irq[2]=1 -> int taken 2 cycles after irq rises (sync + take), rnpc=32'h4180, cause[6:2]=0, cause[10]=1; with IM bit cleared -> never taken.
REQ-041 In HANDLER, eret=1 with epc=32'h3010 -> rnpc=32'h3010, flush=1, next cycle EXL=0; eret and exc_req together -> rnpc=32'h4180, EXL stays 1, epc unchanged.
REQ-042 exc_req=1 with stall=1 -> rnpc=npc, flush=0, no state change; stall drops -> taken that cycle.
REQ-043 rst_n pulsed low while EXL=1, epc=32'h3010 -> all registers 0 immediately, rnpc=npc.
